// File: rtl/adc_capture_pkg.sv
// Shared types and constants for the multi-lane ADC SPI capture engine.
package adc_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CNV   = 2'd1,
    ST_SHIFT = 2'd2,
    ST_STORE = 2'd3
  } state_e;

  localparam int ENTRY_W = 33;
  localparam int OVF_W   = 16;
  localparam int AXIS_W  = 32;

  // Legal build: lanes 1..32, sample 1..32 bits, FIFO a power of two holding one full set.
  function automatic bit cfg_ok(input int n_ch, input int sample_w, input int fifo_depth);
    return (n_ch >= 1) && (n_ch <= 32) && (sample_w >= 1) && (sample_w <= 32) &&
           (fifo_depth >= 1) && ((fifo_depth & (fifo_depth - 1)) == 0) &&
           (fifo_depth >= n_ch);
  endfunction

endpackage

// File: rtl/adc_spi_capture_axis_if.sv
// AXI-Stream beat bundle. A beat transfers on tvalid & tready; while tvalid is high and
// tready low, tdata/tstrb/tlast hold, and tvalid only drops after a transfer.
interface adc_spi_capture_axis_if;
  logic        tvalid;
  logic [31:0] tdata;
  logic [3:0]  tstrb;
  logic        tlast;
  logic        tready;

  modport master (output tvalid, output tdata, output tstrb, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tstrb, input tlast, output tready);
endinterface

// File: rtl/adc_spi_capture_axis_sync_fifo.sv
// Single-clock FIFO with a registered output stage; o_count covers memory plus output register.
module sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_wr_en,
  input  logic [WIDTH-1:0]             i_wr_data,
  input  logic                         i_rd_ready,
  output logic                         o_rd_valid,
  output logic [WIDTH-1:0]             o_rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_full,
  output logic                         o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_mem_cnt;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;

  logic w_load;
  logic w_mem_rd;
  logic w_bypass;
  logic w_mem_wr;

  // The output register refills whenever it is empty or being consumed; an empty memory
  // lets a write go straight to the output so data appears one cycle after the write.
  assign w_load   = !r_out_valid || i_rd_ready;
  assign w_mem_rd = w_load && (r_mem_cnt != '0);
  assign w_bypass = w_load && (r_mem_cnt == '0) && i_wr_en;
  assign w_mem_wr = i_wr_en && !w_bypass && (r_mem_cnt != CW'(DEPTH));

  always_ff @(posedge i_clk) begin
    if (w_mem_wr) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_mem_cnt   <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      if (w_mem_wr) begin
        r_wr_ptr <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + AW'(1);
      end
      if (w_mem_rd) begin
        r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + AW'(1);
      end
      if (w_mem_wr && !w_mem_rd) begin
        r_mem_cnt <= r_mem_cnt + CW'(1);
      end else if (!w_mem_wr && w_mem_rd) begin
        r_mem_cnt <= r_mem_cnt - CW'(1);
      end
      if (w_load) begin
        if (w_mem_rd) begin
          r_out_valid <= 1'b1;
          r_out_data  <= r_mem[r_rd_ptr];
        end else if (w_bypass) begin
          r_out_valid <= 1'b1;
          r_out_data  <= i_wr_data;
        end else begin
          r_out_valid <= 1'b0;
        end
      end
    end
  end

  assign o_rd_valid = r_out_valid;
  assign o_rd_data  = r_out_data;
  assign o_count    = r_mem_cnt + CW'(r_out_valid);
  assign o_full     = (o_count == CW'(DEPTH));
  assign o_empty    = !r_out_valid;

endmodule

// File: rtl/adc_spi_capture_axis.sv
// Multi-lane ADC capture: CNV pulse, parallel SPI shift-in, FIFO buffering, framed AXI-Stream out.
module adc_spi_capture_axis
  import adc_capture_pkg::*;
#(
  parameter int N_CH       = 8,
  parameter int SAMPLE_W   = 16,
  parameter int SIGNED_EXT = 1,
  parameter int CLK_DIV    = 2,
  parameter int CNV_CYCLES = 40,
  parameter int FIFO_DEPTH = 16,
  parameter int FRAME_LEN  = 256
) (
  input  logic              m00_axis_aclk,
  input  logic              m00_axis_aresetn,
  input  logic              enable,
  input  logic              trig,
  output logic              ADC_cnv,
  output logic              ADC_cs_n,
  output logic              ADC_SPI_clk,
  input  logic [N_CH-1:0]   ADC_SPI,
  output logic              sample,
  output logic              m00_axis_tvalid,
  output logic [31:0]       m00_axis_tdata,
  output logic [3:0]        m00_axis_tstrb,
  output logic              m00_axis_tlast,
  input  logic              m00_axis_tready,
  output logic [OVF_W-1:0]  overflow_cnt,
  output logic [1:0]        o_dbg_state
);

  localparam int LANE_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CW     = $clog2(FIFO_DEPTH + 1);

  if (!cfg_ok(N_CH, SAMPLE_W, FIFO_DEPTH)) begin : g_cfg_err
    $error("adc_spi_capture_axis: illegal N_CH / SAMPLE_W / FIFO_DEPTH combination");
  end

  state_e              r_state;
  logic [31:0]         r_cnt;
  logic [31:0]         r_div;
  logic [5:0]          r_bit;
  logic [LANE_W-1:0]   r_lane;
  logic                r_store_ok;
  logic [SAMPLE_W-1:0] r_shift [N_CH];
  logic [31:0]         r_frame;
  logic [OVF_W-1:0]    r_ovf;

  logic                w_div_end;
  logic                w_bit_last;
  logic                w_store_first;
  logic                w_room;
  logic                w_ok;
  logic                w_wr_en;
  logic                w_lane_last;
  logic                w_last;
  logic [SAMPLE_W-1:0] w_sample;
  logic [AXIS_W-1:0]   w_ext;
  logic [ENTRY_W-1:0]  w_wr_data;
  logic                w_rd_valid;
  logic [ENTRY_W-1:0]  w_rd_data;
  logic [CW-1:0]       w_count;
  logic                w_full;
  logic                w_empty;

  assign w_div_end     = (r_div == 32'(2 * CLK_DIV - 1));
  assign w_bit_last    = (r_bit == 6'(SAMPLE_W - 1));
  assign w_store_first = (r_state == ST_STORE) && (r_cnt == 32'd0);

  // Admission is decided once, on occupancy seen in the first STORE cycle; the set is
  // then written whole or dropped whole so the host never sees a torn conversion.
  assign w_room      = !w_full && ((32'(FIFO_DEPTH) - 32'(w_count)) >= 32'(N_CH));
  assign w_ok        = w_store_first ? w_room : r_store_ok;
  assign w_wr_en     = (r_state == ST_STORE) && w_ok;
  assign w_lane_last = (r_lane == LANE_W'(N_CH - 1));
  assign w_last      = w_lane_last && (r_frame == 32'(FRAME_LEN - 1));
  assign w_sample    = r_shift[r_lane];
  assign w_ext       = (SIGNED_EXT != 0) ? 32'($signed(w_sample)) : 32'(w_sample);
  assign w_wr_data   = {w_last, w_ext};

  always_ff @(posedge m00_axis_aclk) begin
    if (!m00_axis_aresetn) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_div      <= '0;
      r_bit      <= '0;
      r_lane     <= '0;
      r_store_ok <= 1'b0;
      r_frame    <= '0;
      r_ovf      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (trig && enable) begin
            r_state <= ST_CNV;
            r_cnt   <= '0;
          end
        end
        ST_CNV: begin
          if (r_cnt == 32'(CNV_CYCLES - 1)) begin
            r_state <= ST_SHIFT;
            r_div   <= '0;
            r_bit   <= '0;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        ST_SHIFT: begin
          if (w_div_end) begin
            r_div <= '0;
            r_bit <= r_bit + 6'd1;
            if (w_bit_last) begin
              r_state <= ST_STORE;
              r_cnt   <= '0;
              r_lane  <= '0;
            end
          end else begin
            r_div <= r_div + 32'd1;
          end
        end
        ST_STORE: begin
          r_cnt      <= 32'd1;
          r_store_ok <= w_ok;
          if (!w_ok) begin
            r_state <= ST_IDLE;
            if (r_ovf != '1) begin
              r_ovf <= r_ovf + OVF_W'(1);
            end
          end else if (w_lane_last) begin
            r_state <= ST_IDLE;
            r_frame <= (r_frame == 32'(FRAME_LEN - 1)) ? 32'd0 : r_frame + 32'd1;
          end else begin
            r_lane <= r_lane + LANE_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Lanes are captured at the end of each high phase, MSB first.
  always_ff @(posedge m00_axis_aclk) begin
    if (r_state == ST_SHIFT && w_div_end) begin
      for (int l = 0; l < N_CH; l++) begin
        r_shift[l] <= (r_shift[l] << 1) | SAMPLE_W'(ADC_SPI[l]);
      end
    end
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk      (m00_axis_aclk),
    .i_rst_n    (m00_axis_aresetn),
    .i_wr_en    (w_wr_en),
    .i_wr_data  (w_wr_data),
    .i_rd_ready (u_axis.tready),
    .o_rd_valid (w_rd_valid),
    .o_rd_data  (w_rd_data),
    .o_count    (w_count),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  adc_spi_capture_axis_if u_axis ();

  assign u_axis.tvalid = w_rd_valid && !w_empty;
  assign u_axis.tdata  = w_rd_data[AXIS_W-1:0];
  assign u_axis.tlast  = w_rd_data[ENTRY_W-1];
  assign u_axis.tstrb  = 4'hF;
  assign u_axis.tready = m00_axis_tready;

  assign m00_axis_tvalid = u_axis.tvalid;
  assign m00_axis_tdata  = u_axis.tdata;
  assign m00_axis_tlast  = u_axis.tlast;
  assign m00_axis_tstrb  = u_axis.tstrb;

  assign ADC_cnv      = (r_state == ST_CNV);
  assign ADC_cs_n     = (r_state != ST_SHIFT);
  assign ADC_SPI_clk  = (r_state == ST_SHIFT) && (r_div >= 32'(CLK_DIV));
  assign sample       = w_store_first;
  assign overflow_cnt = r_ovf;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_adc_spi_capture_axis.sv
// Directed bench for adc_spi_capture_axis with an SPI ADC model and an AXI-Stream scoreboard.
module tb_adc_spi_capture_axis;

  localparam int N_CH       = 2;
  localparam int SAMPLE_W   = 16;
  localparam int CLK_DIV    = 2;
  localparam int CNV_CYCLES = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int FRAME_LEN  = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            enable = 1'b0;
  logic            trig = 1'b0;
  logic            tready = 1'b0;
  logic [N_CH-1:0] adc_spi = '0;
  logic            adc_cnv, adc_cs_n, adc_sclk, sample;
  logic [15:0]     ovf;
  logic [1:0]      dbg_state;

  adc_spi_capture_axis_if axis_mon ();
  assign axis_mon.tready = tready;

  adc_spi_capture_axis #(
    .N_CH(N_CH), .SAMPLE_W(SAMPLE_W), .SIGNED_EXT(1), .CLK_DIV(CLK_DIV),
    .CNV_CYCLES(CNV_CYCLES), .FIFO_DEPTH(FIFO_DEPTH), .FRAME_LEN(FRAME_LEN)
  ) dut (
    .m00_axis_aclk(clk), .m00_axis_aresetn(rst_n), .enable(enable), .trig(trig),
    .ADC_cnv(adc_cnv), .ADC_cs_n(adc_cs_n), .ADC_SPI_clk(adc_sclk), .ADC_SPI(adc_spi),
    .sample(sample), .m00_axis_tvalid(axis_mon.tvalid), .m00_axis_tdata(axis_mon.tdata),
    .m00_axis_tstrb(axis_mon.tstrb), .m00_axis_tlast(axis_mon.tlast),
    .m00_axis_tready(axis_mon.tready), .overflow_cnt(ovf), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [32:0] exp_q[$];
  int          exp_frame = 0;
  logic [15:0] adc_val [N_CH];
  int          bit_idx = 0;
  logic        prev_sclk = 1'b0;
  int          rise_cnt = 0;
  int          sample_cnt = 0;
  int          beat_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ADC model: MSB on the bus when cs_n falls, next bit after each SPI clock falling edge.
  always @(negedge clk) begin
    logic [15:0] v;
    if (adc_cs_n) bit_idx = 0;
    else if (prev_sclk && !adc_sclk) bit_idx++;
    if (adc_sclk && !prev_sclk) rise_cnt++;
    prev_sclk = adc_sclk;
    if (sample) sample_cnt++;
    for (int l = 0; l < N_CH; l++) begin
      v = adc_val[l];
      adc_spi[l] = (bit_idx < 16) ? v[15 - bit_idx] : 1'b0;
    end
  end

  // Scoreboard: every valid beat must match the queue head, stalled or not.
  always @(negedge clk) begin
    if (rst_n && axis_mon.tvalid) begin
      check("beat_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        check("beat_data", {31'b0, axis_mon.tlast, axis_mon.tdata}, 64'(exp_q[0]));
        if (tready) begin
          void'(exp_q.pop_front());
          beat_cnt++;
        end
      end
    end
  end

  function automatic logic [31:0] sext(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    exp_frame = 0;
  endtask

  task automatic pulse_trig();
    @(posedge clk); #1 trig = 1'b1;
    @(posedge clk); #1 trig = 1'b0;
  endtask

  task automatic push_conv(input logic [15:0] v0, input logic [15:0] v1);
    exp_q.push_back({1'b0, sext(v0)});
    exp_q.push_back({(exp_frame == FRAME_LEN - 1), sext(v1)});
    exp_frame = (exp_frame == FRAME_LEN - 1) ? 0 : exp_frame + 1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (dbg_state != 2'd0 && n < budget) begin tick(1); n++; end
    check("idle_timeout", 64'(n < budget), 64'd1);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin tick(1); n++; end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic run_conv(input logic [15:0] v0, input logic [15:0] v1, input bit stored);
    adc_val[0] = v0;
    adc_val[1] = v1;
    if (stored) push_conv(v0, v1);
    pulse_trig();
    wait_idle(200);
  endtask

  initial begin
    int s0, r0, b0;
    logic [15:0] a, b;
    adc_val[0] = '0;
    adc_val[1] = '0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    check("rst_outs", {10'b0, adc_cnv, adc_cs_n, adc_sclk, sample, axis_mon.tvalid,
          axis_mon.tlast, ovf, axis_mon.tdata}, {10'b0, 6'b010000, 16'h0, 32'h0});
    check("rst_state", 64'(dbg_state), 64'd0);
    check("tstrb", 64'(axis_mon.tstrb), 64'hF);

    // 1: single conversion, exact timing
    enable = 1'b1; tready = 1'b1;
    adc_val[0] = 16'h8001; adc_val[1] = 16'h1234;
    push_conv(16'h8001, 16'h1234);
    s0 = sample_cnt; r0 = rise_cnt;
    pulse_trig();
    check("cnv_t1", {62'b0, adc_cnv, adc_cs_n}, 64'b11);
    tick(3);
    check("cnv_t4", 64'(adc_cnv), 64'd1);
    tick(1);
    check("shift_t5", {61'b0, adc_cnv, adc_cs_n, adc_sclk}, 64'b000);
    tick(2);
    check("sclk_hi_t7", 64'(adc_sclk), 64'd1);
    tick(62);
    check("sample_t69", {62'b0, sample, adc_cs_n}, 64'b11);
    tick(1);
    check("sample_t70", 64'(sample), 64'd0);
    check("tvalid_t70", {31'b0, axis_mon.tvalid, axis_mon.tdata}, {31'b0, 1'b1, 32'hFFFF8001});
    wait_idle(200);
    drain(50);
    check("spi_rises", 64'(rise_cnt - r0), 64'd16);
    check("sample_pulses", 64'(sample_cnt - s0), 64'd1);

    // 2: framing across three conversions
    do_reset();
    b0 = beat_cnt;
    for (int i = 0; i < 3; i++) begin
      a = 16'($urandom_range(0, 65535));
      b = 16'($urandom_range(0, 65535));
      run_conv(a, b, 1'b1);
    end
    drain(50);
    check("frame_beats", 64'(beat_cnt - b0), 64'd6);

    // 3: backpressure, overflow drop, stall
    do_reset();
    tready = 1'b0;
    b0 = beat_cnt;
    for (int i = 0; i < 4; i++) begin
      a = 16'($urandom_range(0, 65535));
      b = 16'($urandom_range(0, 65535));
      run_conv(a, b, 1'b1);
    end
    check("stall_valid", 64'(axis_mon.tvalid), 64'd1);
    check("no_drop_yet", 64'(ovf), 64'd0);
    run_conv(16'h5555, 16'hAAAA, 1'b0);
    check("ovf_one", 64'(ovf), 64'd1);
    tick(5);
    tready = 1'b1;
    drain(50);
    check("ovf_beats", 64'(beat_cnt - b0), 64'd8);

    // 4: trig ignored outside IDLE and while disabled
    s0 = sample_cnt;
    adc_val[0] = 16'h7F00; adc_val[1] = 16'h00FF;
    push_conv(16'h7F00, 16'h00FF);
    pulse_trig();
    tick(1);
    pulse_trig();
    tick(10);
    pulse_trig();
    wait_idle(200);
    check("one_sample", 64'(sample_cnt - s0), 64'd1);
    tick(20);
    check("no_retrig", 64'(dbg_state), 64'd0);
    drain(50);
    enable = 1'b0;
    pulse_trig();
    tick(3);
    check("disabled_idle", {62'b0, dbg_state}, 64'd0);
    check("disabled_cnv", 64'(adc_cnv), 64'd0);
    tick(80);
    check("disabled_samples", 64'(sample_cnt - s0), 64'd1);
    enable = 1'b1;

    // 5: reset mid-SHIFT
    s0 = sample_cnt; b0 = beat_cnt;
    adc_val[0] = 16'h1111; adc_val[1] = 16'h2222;
    pulse_trig();
    tick(30);
    check("in_shift", 64'(adc_cs_n), 64'd0);
    rst_n = 1'b0;
    tick(1);
    check("abort_outs", {60'b0, adc_cs_n, adc_sclk, axis_mon.tvalid, adc_cnv}, 64'b1000);
    check("abort_ovf", 64'(ovf), 64'd0);
    check("abort_state", 64'(dbg_state), 64'd0);
    rst_n = 1'b1;
    exp_frame = 0;
    tick(100);
    check("abort_no_beats", 64'(beat_cnt - b0), 64'd0);
    check("abort_no_sample", 64'(sample_cnt - s0), 64'd0);
    run_conv(16'hFFFF, 16'h0001, 1'b1);
    drain(50);
    check("post_abort_beats", 64'(beat_cnt - b0), 64'd2);

    // 6: overflow counter saturation
    do_reset();
    tready = 1'b0;
    for (int i = 0; i < 4; i++) run_conv(16'(i * 16'h1357), 16'(16'hC000 + i), 1'b1);
    @(posedge clk); #1 force dut.r_ovf = 16'hFFFD;
    @(posedge clk); #1 release dut.r_ovf;
    run_conv(16'h0F0F, 16'hF0F0, 1'b0);
    check("ovf_fffe", 64'(ovf), 64'hFFFE);
    run_conv(16'h0F0F, 16'hF0F0, 1'b0);
    check("ovf_ffff", 64'(ovf), 64'hFFFF);
    run_conv(16'h0F0F, 16'hF0F0, 1'b0);
    check("ovf_sat", 64'(ovf), 64'hFFFF);
    tready = 1'b1;
    drain(50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
